// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-lite bus types, memory-map constants and byte-lane helper for the SRAM slave slice.
package ahb_sram_slave_pkg;

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } transfer_kind_t;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } transfer_size_t;

  typedef enum logic {
    RESP_OKAY  = 1'b0,
    RESP_ERROR = 1'b1
  } transfer_response_t;

  localparam logic [31:0] MMAP_SRAM0_BASE = 32'h0000_0000;
  localparam logic [31:0] MMAP_SRAM1_BASE = 32'h0001_0000;

  // Replace only the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      else       merged[8*i +: 8] = old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_if.sv
// Bus-side signal bundle between the AHB-lite fabric and one SRAM slave slot.
interface ahb_sram_slave_if;
  import ahb_sram_slave_pkg::*;

  logic               sel;
  logic [31:0]        addr;
  logic               write;
  transfer_size_t     size;
  transfer_kind_t     trans;
  logic               ready_in;
  logic [31:0]        wdata;
  logic [31:0]        rdata;
  logic               ready_out;
  transfer_response_t resp;

  modport master (
    output sel, addr, write, size, trans, ready_in, wdata,
    input  rdata, ready_out, resp
  );

  modport slave (
    input  sel, addr, write, size, trans, ready_in, wdata,
    output rdata, ready_out, resp
  );

endinterface

// File: rtl/ahb_sram_slave_lane_mask.sv
// Byte-enable decode for a sized transfer plus detection of misaligned half/word accesses.
module ahb_sram_lane_mask
  import ahb_sram_slave_pkg::*;
(
  input  transfer_size_t size,
  input  logic [1:0]     off,
  output logic [3:0]     be,
  output logic           misalign
);

  // Decode active lanes; an illegal size enables nothing and is flagged by the caller
  always_comb begin
    be       = 4'b0000;
    misalign = 1'b0;
    case (size)
      SZ_BYTE: begin
        be       = 4'b0001 << off;
        misalign = 1'b0;
      end
      SZ_HALF: begin
        if (off[1]) be = 4'b1100;
        else        be = 4'b0011;
        misalign = off[0];
      end
      SZ_WORD: begin
        be       = 4'b1111;
        misalign = (off != 2'b00);
      end
      default: begin
        be       = 4'b0000;
        misalign = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-lite slave fronting a word-organised SRAM with OKAY / two-cycle ERROR responses.
// Optional wait states per valid data phase are built only when AHB_SRAM_WAIT_EN is defined.
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = MMAP_SRAM0_BASE,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic             clk,
  input logic             rst,
  ahb_sram_slave_if.slave bus
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SRAM_BYTES = 32'(DEPTH_WORDS) * 32'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_ERR1 = 2'b10,
    S_ERR2 = 2'b11
  } state_t;

`ifdef AHB_SRAM_WAIT_EN
  localparam state_t     VALID_NEXT = S_WAIT;
  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES);
  logic [3:0] wait_cnt_r;
`else
  localparam state_t VALID_NEXT = S_IDLE;
`endif

  if (WAIT_CYCLES < 32'd1 || WAIT_CYCLES > 32'd15 || DEPTH_WORDS < 32'd2 ||
      (DEPTH_WORDS & (DEPTH_WORDS - 32'd1)) != 32'd0) begin : g_bad_cfg
    $error("ahb_sram_slave: unsupported DEPTH_WORDS/WAIT_CYCLES");
  end

  state_t             state_r, state_s;
  logic               ready_r, ready_s;
  transfer_response_t resp_r, resp_s;
  logic [31:0]        rdata_r;

  logic [31:0]        off_s;
  logic [AW-1:0]      idx_s;
  logic [3:0]         be_s;
  logic               misalign_s;
  logic               err_s;
  logic               accept_s;
  logic               commit_s;
  logic [31:0]        rd_word_s;

  logic               dp_valid_r;
  logic               dp_write_r;
  logic               dp_err_r;
  logic [3:0]         dp_be_r;
  logic [AW-1:0]      dp_idx_r;

  logic [31:0]        mem_r [DEPTH_WORDS];

  // Below-base addresses wrap to large offsets and fall into the range error
  assign off_s    = bus.addr - BASE_ADDR;
  assign idx_s    = off_s[AW+1:2];
  assign accept_s = bus.sel & bus.ready_in &
                    ((bus.trans == TR_NONSEQ) | (bus.trans == TR_SEQ)) &
                    ((state_r == S_IDLE) | (state_r == S_ERR2));
  assign err_s    = (off_s >= SRAM_BYTES) | (bus.size == SZ_ILLEGAL) | misalign_s;
  assign commit_s = dp_valid_r & dp_write_r & ~dp_err_r & ready_r;

  ahb_sram_lane_mask u_lane_mask (
    .size     (bus.size),
    .off      (off_s[1:0]),
    .be       (be_s),
    .misalign (misalign_s)
  );

  // Read port with bypass of a write committing on the same edge
  always_comb begin
    rd_word_s = mem_r[idx_s];
    if (commit_s && (dp_idx_r == idx_s)) begin
      rd_word_s = merge_lanes(mem_r[dp_idx_r], bus.wdata, dp_be_r);
    end else begin
      rd_word_s = mem_r[idx_s];
    end
  end

  // Data-phase FSM next state
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_ERR2: begin
        if (accept_s && err_s) state_s = S_ERR1;
        else if (accept_s)     state_s = VALID_NEXT;
        else                   state_s = S_IDLE;
      end
      S_ERR1: state_s = S_ERR2;
`ifdef AHB_SRAM_WAIT_EN
      S_WAIT: begin
        if (wait_cnt_r <= 4'd1) state_s = S_IDLE;
        else                    state_s = S_WAIT;
      end
`endif
      default: state_s = S_IDLE;
    endcase
  end

  // Bus outputs decoded from the next state so they leave a flop
  always_comb begin
    ready_s = 1'b1;
    resp_s  = RESP_OKAY;
    case (state_s)
      S_WAIT:  begin ready_s = 1'b0; resp_s = RESP_OKAY;  end
      S_ERR1:  begin ready_s = 1'b0; resp_s = RESP_ERROR; end
      S_ERR2:  begin ready_s = 1'b1; resp_s = RESP_ERROR; end
      default: begin ready_s = 1'b1; resp_s = RESP_OKAY;  end
    endcase
  end

`ifdef AHB_SRAM_WAIT_EN
  // Load the wait budget on entry to S_WAIT and count it down while held
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                           wait_cnt_r <= 4'd0;
    else if ((state_s == S_WAIT) && (state_r != S_WAIT)) wait_cnt_r <= WAIT_LOAD;
    else if (state_r == S_WAIT)                          wait_cnt_r <= wait_cnt_r - 4'd1;
    else                                                 wait_cnt_r <= wait_cnt_r;
  end
`endif

  // Control state, captured address phase and read data register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= S_IDLE;
      ready_r    <= 1'b1;
      resp_r     <= RESP_OKAY;
      rdata_r    <= 32'h0000_0000;
      dp_valid_r <= 1'b0;
      dp_write_r <= 1'b0;
      dp_err_r   <= 1'b0;
      dp_be_r    <= 4'b0000;
      dp_idx_r   <= '0;
    end else begin
      state_r <= state_s;
      ready_r <= ready_s;
      resp_r  <= resp_s;
      if (accept_s) begin
        dp_valid_r <= 1'b1;
        dp_write_r <= bus.write;
        dp_err_r   <= err_s;
        dp_be_r    <= be_s;
        dp_idx_r   <= idx_s;
        if (!bus.write) rdata_r <= err_s ? 32'h0000_0000 : rd_word_s;
      end else if (ready_r) begin
        dp_valid_r <= 1'b0;
      end
    end
  end

  // SRAM array; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (commit_s) mem_r[dp_idx_r] <= merge_lanes(mem_r[dp_idx_r], bus.wdata, dp_be_r);
  end

  assign bus.ready_out = ready_r;
  assign bus.resp      = resp_r;
  assign bus.rdata     = rdata_r;

endmodule
